// File: rtl/fifo_ecc_pkg.sv
// Shared SECDED helpers for the FIFO spill memory: check-bit sizing, Hamming encode/decode.
// Data and check words are zero-extended to MAX_DW/MAX_EW so one function body serves any width.
package fifo_ecc_pkg;

  localparam int MAX_DW  = 64;
  localparam int MAX_EW  = 8;
  localparam int MAX_POS = MAX_DW + MAX_EW;

  typedef enum logic {INIT, RUN} mem_st_e;

  typedef struct packed {
    logic [MAX_DW-1:0] data;
    logic              cerr;
    logic              uerr;
  } ecc_res_t;

  function automatic int ecc_hbits(input int dw);
    int r;
    r = 0;
    for (int i = 1; i < MAX_EW; i++) begin
      if (r == 0 && (1 << i) >= dw + i + 1) r = i;
    end
    return r;
  endfunction

  function automatic int ecc_width(input int dw);
    return ecc_hbits(dw) + 1;
  endfunction

  // Hamming check bits: data occupies the non-power-of-two codeword positions.
  function automatic logic [MAX_EW-1:0] ecc_chk(input logic [MAX_DW-1:0] d, input int dw);
    int r;
    int j;
    logic [MAX_EW-1:0] c;
    r = ecc_hbits(dw);
    j = 0;
    c = '0;
    for (int p = 1; p < MAX_POS; p++) begin
      if (p <= dw + r && (p & (p - 1)) != 0) begin
        for (int b = 0; b < MAX_EW; b++) begin
          if (((p >> b) & 1) != 0) c[b[2:0]] = c[b[2:0]] ^ d[j[5:0]];
        end
        j++;
      end
    end
    return c;
  endfunction

  function automatic logic [MAX_EW-1:0] ecc_enc(input logic [MAX_DW-1:0] d, input int dw);
    logic [MAX_EW-1:0] c;
    int r;
    r = ecc_hbits(dw);
    c = ecc_chk(d, dw);
    c[r[2:0]] = ^d ^ ^c;
    return c;
  endfunction

  function automatic ecc_res_t ecc_dec(input logic [MAX_DW-1:0] d, input logic [MAX_EW-1:0] e,
                                       input int dw);
    ecc_res_t res;
    logic [MAX_EW-1:0] syn;
    logic pmis;
    int r;
    int s;
    int j;
    r = ecc_hbits(dw);
    syn = (ecc_chk(d, dw) ^ e) & MAX_EW'((1 << r) - 1);
    pmis = ^d ^ ^e;
    s = int'(syn);
    res.data = d;
    res.cerr = 1'b0;
    res.uerr = 1'b0;
    if (s != 0 && pmis) begin
      res.cerr = 1'b1;
      j = 0;
      // A syndrome pointing at a check-bit position leaves the data untouched.
      for (int p = 1; p < MAX_POS; p++) begin
        if (p <= dw + r && (p & (p - 1)) != 0) begin
          if (p == s) res.data[j[5:0]] = ~d[j[5:0]];
          j++;
        end
      end
    end else if (s != 0) begin
      res.uerr = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_ecc_dec.sv
// Combinational SECDED decoder for one stored word; raw data passes through on uncorrectable errors.
module fifo_ecc_dec
  import fifo_ecc_pkg::*;
#(
  parameter int DW    = 32,
  parameter int ECC_W = ecc_width(DW)
) (
  input  logic [DW-1:0]    i_data,
  input  logic [ECC_W-1:0] i_ecc,
  output logic [DW-1:0]    o_data,
  output logic             o_cerr,
  output logic             o_uerr
);

  ecc_res_t res;
  logic     unused_res;

  always_comb begin
    res = ecc_dec(MAX_DW'(i_data), MAX_EW'(i_ecc), DW);
  end

  assign o_data     = res.data[DW-1:0];
  assign o_cerr     = res.cerr;
  assign o_uerr     = res.uerr;
  assign unused_res = ^res.data;

endmodule

// File: rtl/fifo_ecc_mem.sv
// ECC-protected simple dual-port spill memory: zero-fills itself after reset, then serves
// read-first accesses with MEM_RD_LAT latency, error injection and error statistics.
module fifo_ecc_mem
  import fifo_ecc_pkg::*;
#(
  parameter int MEM_DEP    = 256,
  parameter int DW         = 32,
  parameter int MEM_RD_LAT = 2,
  parameter int MEM_AW     = $clog2(MEM_DEP),
  parameter int ECC_W      = ecc_width(DW)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mem_wr,
  input  logic [MEM_AW-1:0] i_mem_waddr,
  input  logic [DW-1:0]     i_mem_wdata,
  input  logic              i_mem_rd,
  input  logic [MEM_AW-1:0] i_mem_raddr,
  output logic [DW-1:0]     o_mem_rdata,
  output logic              o_mem_rvld,
  output logic              o_mem_cerr,
  output logic              o_mem_uerr,
  input  logic              i_inj_cerr,
  input  logic              i_inj_uerr,
  output logic              o_init_done,
  input  logic              i_cnt_clr,
  output logic [15:0]       o_cerr_cnt,
  output logic [15:0]       o_uerr_cnt,
  output logic [MEM_AW-1:0] o_uerr_addr,
  output logic              o_uerr_addr_vld
);

  localparam int WW    = DW + ECC_W;
  localparam int N_DLY = MEM_RD_LAT - 1;
  localparam logic [MAX_EW-1:0] ZERO_ECC = ecc_enc(MAX_DW'(0), DW);

  mem_st_e           st_q, st_d;
  logic [MEM_AW-1:0] init_ptr_q, init_ptr_d;
  logic              init_done_q, init_done_d;

  always_comb begin
    st_d        = st_q;
    init_ptr_d  = init_ptr_q;
    init_done_d = init_done_q;
    if (st_q == INIT) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == MEM_AW'(MEM_DEP - 1)) begin
        st_d        = RUN;
        init_done_d = 1'b1;
        init_ptr_d  = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q        <= INIT;
      init_ptr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      init_ptr_q  <= init_ptr_d;
      init_done_q <= init_done_d;
    end
  end

  assign o_init_done = init_done_q;

  logic [DW-1:0]     wr_flip;
  logic [MAX_EW-1:0] wr_ecc_full;
  logic              unused_ecc;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [WW-1:0]     mem_wword;

  // Check bits always come from the clean data so injected flips show up as real errors.
  always_comb begin
    wr_flip = '0;
    if (i_inj_uerr)      wr_flip = DW'(3);
    else if (i_inj_cerr) wr_flip = DW'(1);
    wr_ecc_full = ecc_enc(MAX_DW'(i_mem_wdata), DW);
    if (st_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_ptr_q;
      mem_wword = {ZERO_ECC[ECC_W-1:0], DW'(0)};
    end else begin
      mem_we    = i_mem_wr;
      mem_waddr = i_mem_waddr;
      mem_wword = {wr_ecc_full[ECC_W-1:0], i_mem_wdata ^ wr_flip};
    end
  end

  assign unused_ecc = ^wr_ecc_full;

  logic              rd_en;
  logic [WW-1:0]     mem_q [MEM_DEP];
  logic [WW-1:0]     arr_rdata_q;
  logic              rd_vld_q, rd_vld_d;
  logic [MEM_AW-1:0] rd_addr_q, rd_addr_d;

  assign rd_en = (st_q == RUN) && i_mem_rd;

  // Non-blocking read of the old word gives read-first behaviour on address collisions.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wword;
    if (rd_en)  arr_rdata_q <= mem_q[i_mem_raddr];
  end

  always_comb begin
    rd_vld_d  = rd_en;
    rd_addr_d = rd_en ? i_mem_raddr : rd_addr_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  logic [DW-1:0] dec_data;
  logic          dec_cerr;
  logic          dec_uerr;

  fifo_ecc_dec #(
    .DW    (DW),
    .ECC_W (ECC_W)
  ) u_dec (
    .i_data (arr_rdata_q[DW-1:0]),
    .i_ecc  (arr_rdata_q[WW-1:DW]),
    .o_data (dec_data),
    .o_cerr (dec_cerr),
    .o_uerr (dec_uerr)
  );

  logic [N_DLY:0]    ch_vld, ch_cerr, ch_uerr;
  logic [DW-1:0]     ch_data [N_DLY+1];
  logic [MEM_AW-1:0] ch_addr [N_DLY+1];

  assign ch_vld[0]  = rd_vld_q;
  assign ch_cerr[0] = rd_vld_q & dec_cerr;
  assign ch_uerr[0] = rd_vld_q & dec_uerr;
  assign ch_data[0] = dec_data;
  assign ch_addr[0] = rd_addr_q;

  // Delay stages: flags follow valid every cycle, data and address hold between reads.
  generate
    for (genvar gi = 0; gi < N_DLY; gi++) begin : g_stage
      logic              vld_q, vld_d, cerr_q, cerr_d, uerr_q, uerr_d;
      logic [DW-1:0]     data_q, data_d;
      logic [MEM_AW-1:0] addr_q, addr_d;

      always_comb begin
        vld_d  = ch_vld[gi];
        cerr_d = ch_cerr[gi];
        uerr_d = ch_uerr[gi];
        data_d = ch_vld[gi] ? ch_data[gi] : data_q;
        addr_d = ch_vld[gi] ? ch_addr[gi] : addr_q;
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          vld_q  <= 1'b0;
          cerr_q <= 1'b0;
          uerr_q <= 1'b0;
          data_q <= '0;
          addr_q <= '0;
        end else begin
          vld_q  <= vld_d;
          cerr_q <= cerr_d;
          uerr_q <= uerr_d;
          data_q <= data_d;
          addr_q <= addr_d;
        end
      end

      assign ch_vld[gi+1]  = vld_q;
      assign ch_cerr[gi+1] = cerr_q;
      assign ch_uerr[gi+1] = uerr_q;
      assign ch_data[gi+1] = data_q;
      assign ch_addr[gi+1] = addr_q;
    end
  endgenerate

  assign o_mem_rvld  = ch_vld[N_DLY];
  assign o_mem_cerr  = ch_cerr[N_DLY];
  assign o_mem_uerr  = ch_uerr[N_DLY];
  assign o_mem_rdata = ch_data[N_DLY];

  logic [15:0]       cerr_cnt_q, cerr_cnt_d;
  logic [15:0]       uerr_cnt_q, uerr_cnt_d;
  logic [MEM_AW-1:0] uerr_addr_q, uerr_addr_d;
  logic              uerr_addr_vld_q, uerr_addr_vld_d;

  always_comb begin
    cerr_cnt_d      = cerr_cnt_q;
    uerr_cnt_d      = uerr_cnt_q;
    uerr_addr_d     = uerr_addr_q;
    uerr_addr_vld_d = uerr_addr_vld_q;
    if (i_cnt_clr) begin
      cerr_cnt_d      = '0;
      uerr_cnt_d      = '0;
      uerr_addr_d     = '0;
      uerr_addr_vld_d = 1'b0;
    end else begin
      if (o_mem_cerr && cerr_cnt_q != 16'hFFFF) cerr_cnt_d = cerr_cnt_q + 16'd1;
      if (o_mem_uerr && uerr_cnt_q != 16'hFFFF) uerr_cnt_d = uerr_cnt_q + 16'd1;
      if (o_mem_uerr && !uerr_addr_vld_q) begin
        uerr_addr_d     = ch_addr[N_DLY];
        uerr_addr_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cerr_cnt_q      <= '0;
      uerr_cnt_q      <= '0;
      uerr_addr_q     <= '0;
      uerr_addr_vld_q <= 1'b0;
    end else begin
      cerr_cnt_q      <= cerr_cnt_d;
      uerr_cnt_q      <= uerr_cnt_d;
      uerr_addr_q     <= uerr_addr_d;
      uerr_addr_vld_q <= uerr_addr_vld_d;
    end
  end

  assign o_cerr_cnt      = cerr_cnt_q;
  assign o_uerr_cnt      = uerr_cnt_q;
  assign o_uerr_addr     = uerr_addr_q;
  assign o_uerr_addr_vld = uerr_addr_vld_q;

endmodule

// File: tb/tb_fifo_ecc_mem.sv
// Scoreboard bench for fifo_ecc_mem: reads push expected words, the output monitor pops and compares.
module tb_fifo_ecc_mem;

  localparam int DEP = 256;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int AW  = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_mem_wr;
  logic [AW-1:0] i_mem_waddr;
  logic [DW-1:0] i_mem_wdata;
  logic          i_mem_rd;
  logic [AW-1:0] i_mem_raddr;
  logic [DW-1:0] o_mem_rdata;
  logic          o_mem_rvld;
  logic          o_mem_cerr;
  logic          o_mem_uerr;
  logic          i_inj_cerr;
  logic          i_inj_uerr;
  logic          o_init_done;
  logic          i_cnt_clr;
  logic [15:0]   o_cerr_cnt;
  logic [15:0]   o_uerr_cnt;
  logic [AW-1:0] o_uerr_addr;
  logic          o_uerr_addr_vld;

  fifo_ecc_mem #(
    .MEM_DEP    (DEP),
    .DW         (DW),
    .MEM_RD_LAT (LAT)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_mem_wr        (i_mem_wr),
    .i_mem_waddr     (i_mem_waddr),
    .i_mem_wdata     (i_mem_wdata),
    .i_mem_rd        (i_mem_rd),
    .i_mem_raddr     (i_mem_raddr),
    .o_mem_rdata     (o_mem_rdata),
    .o_mem_rvld      (o_mem_rvld),
    .o_mem_cerr      (o_mem_cerr),
    .o_mem_uerr      (o_mem_uerr),
    .i_inj_cerr      (i_inj_cerr),
    .i_inj_uerr      (i_inj_uerr),
    .o_init_done     (o_init_done),
    .i_cnt_clr       (i_cnt_clr),
    .o_cerr_cnt      (o_cerr_cnt),
    .o_uerr_cnt      (o_uerr_cnt),
    .o_uerr_addr     (o_uerr_addr),
    .o_uerr_addr_vld (o_uerr_addr_vld)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          cerr;
    logic          uerr;
    int            cyc;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_data [DEP];
  int            model_kind [DEP];  // 0 clean, 1 single flip, 2 double flip
  int            rel_cyc;

  // Output monitor: one line per returned read.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst) begin
      if (o_mem_rvld) begin
        if (sb.size() == 0) begin
          check_eq("unexp_rvld", 64'(o_mem_rvld), 64'(0));
        end else begin
          e = sb.pop_front();
          $display("rd addr=%0d data=%08h cerr=%0b uerr=%0b cyc=%0d", e.addr, o_mem_rdata,
                   o_mem_cerr, o_mem_uerr, cyc);
          check_eq("rd_data", 64'(o_mem_rdata), 64'(e.data));
          check_eq("rd_cerr", 64'(o_mem_cerr), 64'(e.cerr));
          check_eq("rd_uerr", 64'(o_mem_uerr), 64'(e.uerr));
          check_eq("rd_lat", 64'(cyc), 64'(e.cyc));
        end
      end else if (o_mem_cerr || o_mem_uerr) begin
        check_eq("err_no_vld", 64'({o_mem_cerr, o_mem_uerr}), 64'(0));
      end
    end
  end

  task automatic idle();
    i_mem_wr    = 1'b0;
    i_mem_waddr = '0;
    i_mem_wdata = '0;
    i_mem_rd    = 1'b0;
    i_mem_raddr = '0;
    i_inj_cerr  = 1'b0;
    i_inj_uerr  = 1'b0;
    i_cnt_clr   = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < DEP; a++) begin
      model_data[a] = '0;
      model_kind[a] = 0;
    end
  endtask

  task automatic op(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic ic, input logic iu, input logic rd, input logic [AW-1:0] ra);
    exp_t e;
    i_mem_wr    = wr;
    i_mem_waddr = wa;
    i_mem_wdata = wd;
    i_inj_cerr  = ic;
    i_inj_uerr  = iu;
    i_mem_rd    = rd;
    i_mem_raddr = ra;
    if (rd) begin
      e.addr = ra;
      e.data = (model_kind[ra] == 2) ? (model_data[ra] ^ 32'h3) : model_data[ra];
      e.cerr = (model_kind[ra] == 1);
      e.uerr = (model_kind[ra] == 2);
      e.cyc  = cyc + LAT;
      sb.push_back(e);
    end
    if (wr) begin
      model_data[wa] = wd;
      model_kind[wa] = iu ? 2 : (ic ? 1 : 0);
    end
    tick(1);
    idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!o_init_done && n < DEP + 20) begin
      tick(1);
      n++;
    end
    check_eq(tag, 64'(cyc - rel_cyc), 64'(DEP));
  endtask

  initial begin
    idle();
    model_clear();
    #2 i_rst = 1'b1;
    tick(2);
    check_eq("rst_rdata", 64'(o_mem_rdata), 64'(0));
    check_eq("rst_rvld", 64'(o_mem_rvld), 64'(0));
    check_eq("rst_cerr", 64'(o_mem_cerr), 64'(0));
    check_eq("rst_uerr", 64'(o_mem_uerr), 64'(0));
    check_eq("rst_init_done", 64'(o_init_done), 64'(0));
    check_eq("rst_cerr_cnt", 64'(o_cerr_cnt), 64'(0));
    check_eq("rst_uerr_cnt", 64'(o_uerr_cnt), 64'(0));
    check_eq("rst_uerr_addr", 64'(o_uerr_addr), 64'(0));
    check_eq("rst_uerr_addr_vld", 64'(o_uerr_addr_vld), 64'(0));

    i_rst   = 1'b0;
    rel_cyc = cyc;
    // Reads during the init sweep must produce nothing.
    i_mem_rd    = 1'b1;
    i_mem_raddr = 8'd4;
    tick(1);
    idle();
    wait_init("init_lat");

    for (int a = 0; a < DEP; a++) op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, AW'(a));
    drain();

    op(1'b1, 8'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, '0);
    op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 8'd5);
    for (int a = 0; a < 8; a++) op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, AW'(a));
    op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 8'd5);
    drain();
    tick(3);
    check_eq("rdata_hold", 64'(o_mem_rdata), 64'(32'hDEADBEEF));

    op(1'b1, 8'd9, 32'h2, 1'b0, 1'b0, 1'b0, '0);
    op(1'b1, 8'd9, 32'h1, 1'b0, 1'b0, 1'b1, 8'd9);
    op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 8'd9);
    drain();

    op(1'b1, 8'd3, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, '0);
    op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 8'd3);
    drain();
    tick(2);
    check_eq("cerr_cnt", 64'(o_cerr_cnt), 64'(1));

    op(1'b1, 8'd7, 32'h12345678, 1'b0, 1'b1, 1'b0, '0);
    op(1'b1, 8'd8, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, '0);
    op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 8'd7);
    op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 8'd8);
    drain();
    tick(2);
    check_eq("uerr_cnt", 64'(o_uerr_cnt), 64'(2));
    check_eq("uerr_addr", 64'(o_uerr_addr), 64'(7));
    check_eq("uerr_addr_vld", 64'(o_uerr_addr_vld), 64'(1));
    check_eq("cerr_cnt_keep", 64'(o_cerr_cnt), 64'(1));

    i_cnt_clr = 1'b1;
    tick(1);
    idle();
    check_eq("clr_cerr_cnt", 64'(o_cerr_cnt), 64'(0));
    check_eq("clr_uerr_cnt", 64'(o_uerr_cnt), 64'(0));
    check_eq("clr_uerr_addr_vld", 64'(o_uerr_addr_vld), 64'(0));
    check_eq("clr_uerr_addr", 64'(o_uerr_addr), 64'(0));

    // A read to a corrupted word is cut off by reset before it returns.
    op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 8'd3);
    i_rst = 1'b1;
    sb.delete();
    model_clear();
    tick(3);
    check_eq("rst2_init_done", 64'(o_init_done), 64'(0));
    check_eq("rst2_cerr_cnt", 64'(o_cerr_cnt), 64'(0));
    i_rst   = 1'b0;
    rel_cyc = cyc;
    tick(2);
    check_eq("rst2_rvld", 64'(o_mem_rvld), 64'(0));
    check_eq("rst2_cerr_cnt_after", 64'(o_cerr_cnt), 64'(0));
    wait_init("init_lat2");
    op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 8'd5);
    op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 8'd3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_ecc_mem.md
# fifo_ecc_mem

Memory-side responder for the FIFO spill port: a simple dual-port storage array with SECDED ECC that services the FIFO's `o_mem_wr`/`o_mem_rd` requests. It returns `i_mem_rdata`, `i_mem_cerr` and `i_mem_uerr` exactly `MEM_RD_LAT` cycles after each read. It zero-initialises itself after reset, supports error injection for test, and keeps error statistics for software.

## Interface
Parameters:
- `MEM_DEP`, 256: number of words.
- `DW`, 32: data width.
- `MEM_RD_LAT`, 2: read latency in cycles. Legal range is at least 1.
- `MEM_AW`, `$clog2(MEM_DEP)`: address width.
- `ECC_W`, `ecc_width(DW)`: check-bit width. Equals 7 for `DW`=32.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `i_mem_wr`  in  1  write request.
- `i_mem_waddr`  in  `MEM_AW`  write address.
- `i_mem_wdata`  in  `DW`  write data.
- `i_mem_rd`  in  1  read request.
- `i_mem_raddr`  in  `MEM_AW`  read address.
- `o_mem_rdata`  out  `DW`  corrected read data.
- `o_mem_rvld`  out  1  read data valid, for checking only.
- `o_mem_cerr`  out  1  single-bit error, corrected.
- `o_mem_uerr`  out  1  double-bit error, uncorrectable.
- `i_inj_cerr`  in  1  on a write, flip data bit 0 before storing.
- `i_inj_uerr`  in  1  on a write, flip data bits 0 and 1 before storing. Takes priority over `i_inj_cerr`.
- `o_init_done`  out  1  initialisation sweep complete.
- `i_cnt_clr`  in  1  synchronous clear of the counters and of the sticky address.
- `o_cerr_cnt`  out  16  saturating count of corrected errors.
- `o_uerr_cnt`  out  16  saturating count of uncorrectable errors.
- `o_uerr_addr`  out  `MEM_AW`  address of the first uncorrectable error since the last clear.
- `o_uerr_addr_vld`  out  1  `o_uerr_addr` holds a captured address.

## Operation
- FSM has two states, INIT and RUN.
- Reset enters INIT. The init pointer starts at 0.
- INIT writes 0 with valid ECC to the address in the init pointer, one address per cycle.
- After address `MEM_DEP`-1 is written, the FSM moves to RUN and `o_init_done`=1.
- In INIT, `i_mem_wr` and `i_mem_rd` are ignored. No read pipeline entry is created.
- In RUN, the write path stores `{ecc_enc(d), d}`, where `d` is `i_mem_wdata` with any injected flips applied. Check bits are computed on the unflipped data.
- Read path decodes the stored word with the syndrome:
  - Zero syndrome: no error.
  - Non-zero syndrome with overall parity mismatch: correct the single bit and raise `o_mem_cerr`. A flip in a check bit is also reported as `o_mem_cerr`, with the data unchanged.
  - Non-zero syndrome with overall parity matching: raise `o_mem_uerr` and pass the raw data through.
- Write and read in the same cycle:
  - Different addresses: both are performed.
  - Same address: read-first. The read returns the old contents.
- Counters increment by 1 on each `o_mem_cerr` or `o_mem_uerr` pulse and saturate at 0xFFFF.
- On the first uerr since the last clear, capture the read address into `o_uerr_addr` and set `o_uerr_addr_vld`.
- If `i_cnt_clr` coincides with an error pulse, the clear wins.

## Timing
- A read accepted at cycle t gives `o_mem_rvld`, `o_mem_rdata`, `o_mem_cerr` and `o_mem_uerr` valid during cycle t+`MEM_RD_LAT`, each for one cycle.
- The pipeline is fully pipelined: back-to-back reads every cycle are supported.
- Stage layout:
  - Array read registered at t+1.
  - Decode is combinational after the array register.
  - The remaining `MEM_RD_LAT`-1 delay stages are registers carrying data and flags.
- `o_mem_rdata` holds its last value when `o_mem_rvld`=0.
- `o_mem_cerr` and `o_mem_uerr` are 0 when `o_mem_rvld`=0.
- A write at cycle t is visible to a read issued at t+1 or later.
- Counters and the sticky address update one cycle after the error pulse.
- Reset values: `o_mem_rdata`=0, `o_mem_rvld`=0, `o_mem_cerr`=0, `o_mem_uerr`=0, `o_init_done`=0, both counters 0, `o_uerr_addr`=0, `o_uerr_addr_vld`=0. The array is not reset; INIT covers it.
- Reset asserted mid-read: in-flight pipeline valids clear immediately. No error pulses and no counter updates occur for those reads.
- INIT lasts exactly `MEM_DEP` cycles after reset deasserts.

## Structure
- Package `fifo_ecc_pkg` holds:
  - function `ecc_width(dw)`: smallest r with 2^r ≥ dw+r+1, plus 1 for overall parity.
  - functions `ecc_enc` and `ecc_dec`, Hamming SECDED.
  - state enum `mem_st_e` {INIT, RUN}.
- One sub-module, `fifo_ecc_dec`: the combinational SECDED decoder, which the verification team reuses for its scoreboard.
- Array is an inferred `(DW+ECC_W)×MEM_DEP` register/RAM with a registered read.

## Test plan
- Reset, wait for `o_init_done`, read every address → `o_mem_rdata`=0 and no errors. `o_init_done` rises exactly 256 cycles after reset release.
- Write 0xDEADBEEF to address 5 at cycle t, read address 5 at t+1 → 0xDEADBEEF with `o_mem_rvld` at t+3 (`MEM_RD_LAT`=2). Back-to-back reads of addresses 0–7 return data on 8 consecutive cycles.
- Same-cycle write 0x1 and read of address 9, which holds 0x2 → read returns 0x2. The next read returns 0x1.
- Write 0xA5A5A5A5 to address 3 with `i_inj_cerr` → read returns 0xA5A5A5A5, `o_mem_cerr`=1, `o_cerr_cnt`=1.
- Write to address 7 with `i_inj_uerr`, then to address 8 with `i_inj_uerr`, then read 7 then 8 → `o_mem_uerr`=1 on both reads, `o_uerr_cnt`=2, `o_uerr_addr`=7. After `i_cnt_clr`, counters are 0 and `o_uerr_addr_vld`=0.
- Issue a read, then assert `i_rst` one cycle later → no `o_mem_rvld` and no error pulse. INIT restarts.
